// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// No latency or backpressure of its own: types, defaults and a width helper only.
package pll_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABILIZE = 3'd1,
      HOLD      = 3'd2,
      RUN       = 3'd3,
      LOSS      = 3'd4
   } seq_state_t;

   localparam int DEFAULT_SYNC_STAGES = 2;

   // Width of a counter that must reach max(a,b)-1; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single level signal, reset to 0.
// Latency STAGES clock edges; no backpressure (free-running level path).
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, then releases a synchronously-deasserted system reset and ready flag.
// Release takes SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges; no backpressure, status-only outputs.
module pll_reset_sequencer
   import pll_pkg::*;
#(
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES   = 16,
   parameter int COUNT_WIDTH   = 8
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_locked_async,
   input  logic                   i_soft_reset_req,
   input  logic                   i_clear_sticky,
   output logic                   o_sys_reset_n,
   output logic                   o_ready,
   output logic                   o_lock_lost_sticky,
   output logic [COUNT_WIDTH-1:0] o_lock_loss_count,
   output logic [2:0]             o_state
);

   localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

   seq_state_t             r_state;
   seq_state_t             w_next_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_next;
   logic                   w_locked_sync;
   logic                   w_run_next;
   logic                   w_loss;
   logic                   r_sys_reset_n;
   logic                   r_ready;
   logic                   r_sticky;
   logic [COUNT_WIDTH-1:0] r_loss_cnt;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_async   (i_locked_async),
      .o_sync    (w_locked_sync)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= WAIT_LOCK;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next_state = WAIT_LOCK;
      case (r_state)
         WAIT_LOCK: w_next_state = w_locked_sync ? STABILIZE : WAIT_LOCK;
         STABILIZE: begin
            if (!w_locked_sync)            w_next_state = WAIT_LOCK;
            else if (r_cnt == STABLE_LAST) w_next_state = HOLD;
            else                           w_next_state = STABILIZE;
         end
         HOLD: begin
            if (!w_locked_sync)          w_next_state = LOSS;
            else if (r_cnt == HOLD_LAST) w_next_state = RUN;
            else                         w_next_state = HOLD;
         end
         // Lock loss outranks a coincident soft reset request.
         RUN: begin
            if (!w_locked_sync)        w_next_state = LOSS;
            else if (i_soft_reset_req) w_next_state = HOLD;
            else                       w_next_state = RUN;
         end
         LOSS:    w_next_state = WAIT_LOCK;
         default: w_next_state = WAIT_LOCK;
      endcase
   end

   // Counter only runs while staying in a timed state; any transition clears it.
   always_comb begin
      w_cnt_next = '0;
      if ((w_next_state == r_state) && ((r_state == STABILIZE) || (r_state == HOLD))) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_run_next = (w_next_state == RUN);
      w_loss     = (r_state == LOSS);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sys_reset_n <= 1'b0;
         r_ready       <= 1'b0;
         r_sticky      <= 1'b0;
         r_loss_cnt    <= '0;
      end else begin
         r_sys_reset_n <= w_run_next;
         r_ready       <= w_run_next;
         if (w_loss)              r_sticky <= 1'b1;
         else if (i_clear_sticky) r_sticky <= 1'b0;
         if (w_loss && !(&r_loss_cnt)) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
         end
      end
   end

   assign o_sys_reset_n      = r_sys_reset_n;
   assign o_ready            = r_ready;
   assign o_lock_lost_sticky = r_sticky;
   assign o_lock_loss_count  = r_loss_cnt;
   assign o_state            = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: each stimulus pushes the edge and value of the next sys_reset_n change.
module tb_pll_reset_sequencer;
   import pll_pkg::*;

   localparam int SYNC_STAGES   = 2;
   localparam int STABLE_CYCLES = 8;
   localparam int HOLD_CYCLES   = 4;
   localparam int COUNT_WIDTH   = 2;
   // Edge offset from the first sampling edge; that edge itself counts as the first.
   localparam int REL_OFS  = SYNC_STAGES + 1 + STABLE_CYCLES + HOLD_CYCLES - 1;
   localparam int LOSS_OFS = SYNC_STAGES;
   localparam int CNT_MAX  = (1 << COUNT_WIDTH) - 1;

   typedef struct {
      int   cyc;
      logic val;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   locked;
   logic                   soft_req;
   logic                   clr_sticky;
   logic                   sys_rst_n;
   logic                   rdy;
   logic                   sticky;
   logic [COUNT_WIDTH-1:0] loss_cnt;
   logic [2:0]             state;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;
   logic exp_sticky = 1'b0;
   logic prev_rst = 1'b0;
   exp_t sb[$];

   pll_reset_sequencer #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .COUNT_WIDTH   (COUNT_WIDTH)
   ) dut (
      .i_clock            (clk),
      .i_reset_n          (rst_n),
      .i_locked_async     (locked),
      .i_soft_reset_req   (soft_req),
      .i_clear_sticky     (clr_sticky),
      .o_sys_reset_n      (sys_rst_n),
      .o_ready            (rdy),
      .o_lock_lost_sticky (sticky),
      .o_lock_loss_count  (loss_cnt),
      .o_state            (state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (sys_rst_n !== prev_rst) begin
         check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("rst_edge_cyc", 32'(cyc), 32'(e.cyc));
            check_eq("rst_edge_val", 32'(sys_rst_n), 32'(e.val));
            check_eq("ready_val", 32'(rdy), 32'(e.val));
         end
         prev_rst = sys_rst_n;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input int c, input logic v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic wait_sb(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic check_status(input string tag);
      check_eq({tag, "_cnt"}, 32'(loss_cnt), 32'(exp_cnt));
      check_eq({tag, "_sticky"}, 32'(sticky), 32'(exp_sticky));
   endtask

   task automatic relock(input logic soft_in_stab);
      int s;
      locked = 1'b1;
      s = cyc + 1;
      push_exp(s + REL_OFS, 1'b1);
      if (soft_in_stab) begin
         repeat (5) tick();
         soft_req = 1'b1;
         tick();
         soft_req = 1'b0;
      end
      wait_sb(40);
      check_eq("relock_state", 32'(state), 32'(RUN));
   endtask

   task automatic do_loss(input logic with_soft, input logic clr_in_loss);
      int s;
      locked = 1'b0;
      s = cyc + 1;
      push_exp(s + LOSS_OFS, 1'b0);
      if (with_soft) begin
         // Time the pulse to reach the FSM on the same edge as the synchronized drop.
         tick();
         tick();
         soft_req = 1'b1;
      end
      wait_sb(10);
      soft_req = 1'b0;
      check_eq("loss_state", 32'(state), 32'(LOSS));
      if (clr_in_loss) clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      exp_cnt    = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
      exp_sticky = 1'b1;
      check_eq("post_loss_state", 32'(state), 32'(WAIT_LOCK));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int p;
      rst_n = 1'b1;
      locked = 1'b0;
      soft_req = 1'b0;
      clr_sticky = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
      check_eq("rst_ready", 32'(rdy), 32'd0);
      check_eq("rst_state", 32'(state), 32'(WAIT_LOCK));
      check_status("rst");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check_eq("idle_state", 32'(state), 32'(WAIT_LOCK));

      // Acquisition glitch: 5 high samples, 1 low, then high for good.
      locked = 1'b1;
      repeat (5) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      s = cyc + 1;
      push_exp(s + REL_OFS, 1'b1);
      wait_sb(40);
      check_eq("glitch_state", 32'(state), 32'(RUN));
      check_status("glitch");

      // Soft reset in RUN: low for HOLD_CYCLES, count untouched.
      soft_req = 1'b1;
      p = cyc + 1;
      push_exp(p, 1'b0);
      push_exp(p + HOLD_CYCLES, 1'b1);
      tick();
      soft_req = 1'b0;
      check_eq("soft_state", 32'(state), 32'(HOLD));
      wait_sb(20);
      check_status("soft");

      // Lock loss from RUN, then relock with an ignored soft request in STABILIZE.
      do_loss(1'b0, 1'b0);
      check_status("loss1");
      relock(1'b1);

      // Soft request meeting the synchronized drop: loss path wins.
      do_loss(1'b1, 1'b0);
      check_status("loss2");
      relock(1'b0);

      // Saturation and sticky priority.
      do_loss(1'b0, 1'b0);
      check_status("loss3");
      relock(1'b0);
      do_loss(1'b0, 1'b1);
      check_status("loss4_sat");
      tick();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      exp_sticky = 1'b0;
      check_status("clear");

      // Asynchronous reset between edges while in HOLD.
      locked = 1'b1;
      s = cyc + 1;
      push_exp(s + REL_OFS, 1'b1);
      while (cyc < s + SYNC_STAGES + 1 + STABLE_CYCLES) tick();
      check_eq("midhold_state", 32'(state), 32'(HOLD));
      check_status("midhold");
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      locked = 1'b0;
      exp_cnt = 0;
      exp_sticky = 1'b0;
      check_eq("arst_sys_rst_n", 32'(sys_rst_n), 32'd0);
      check_eq("arst_ready", 32'(rdy), 32'd0);
      check_eq("arst_state", 32'(state), 32'(WAIT_LOCK));
      check_status("arst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Clean lock after reset.
      relock(1'b0);
      check_status("clean");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
